// File: rtl/cpu_pkg.sv
// Shared CPU definitions: default datapath width and the ALU select codes
// driven by the control unit on S. The control unit should use these same
// constants so that both ends agree on the encoding.
package cpu_pkg;

    localparam int WIDTH = 16;

    localparam logic [3:0] ALU_NOP = 4'd0;
    localparam logic [3:0] ALU_ADD = 4'd1;
    localparam logic [3:0] ALU_SUB = 4'd2;
    localparam logic [3:0] ALU_AND = 4'd3;
    localparam logic [3:0] ALU_OR  = 4'd4;
    localparam logic [3:0] ALU_XOR = 4'd5;
    localparam logic [3:0] ALU_SHR = 4'd6;
    localparam logic [3:0] ALU_SHL = 4'd7;
    localparam logic [3:0] ALU_NOT = 4'd8;

    // True for select codes the ALU implements. NOP and codes above NOT are
    // treated as illegal when committed with Load_AC.
    function automatic logic alu_legal(input logic [3:0] sel);
        return (sel >= ALU_ADD) && (sel <= ALU_NOT);
    endfunction

endpackage

// File: rtl/acc_datapath_out_fifo.sv
// Output register FIFO between the accumulator and the display/IO consumer.
//
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   push           request to enqueue push_data this edge
//   push_data      value to enqueue
//   out_ready      consumer accepts the head this edge
//   out_data       FIFO head (registered storage, no fall-through)
//   out_valid      FIFO non-empty
//   full           FIFO holds DEPTH entries
//   drop           a push was refused this cycle (full and no pop)
//
// Handshake: a transfer occurs on a rising edge where out_valid and out_ready
// are both 1. out_valid never depends on out_ready, and out_data stays stable
// while out_valid=1 and out_ready=0.
module out_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    output logic             full,
    output logic             drop
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;

    logic empty;
    logic pop_en;
    logic push_en;

    assign empty     = (count_q == '0);
    assign full      = (count_q == CW'(DEPTH));
    assign out_valid = ~empty;
    assign out_data  = mem_q[rd_ptr_q];

    assign pop_en  = out_ready & ~empty;
    // When full, the slot at wr_ptr is the head being popped, so it may be
    // overwritten in the same edge.
    assign push_en = push & (~full | pop_en);
    assign drop    = push & full & ~pop_en;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_en) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop_en) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push_en, pop_en})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/acc_datapath.sv
// Accumulator/ALU execute stage fed by the control unit strobes.
//
// Ports:
//   Clock_Puls, Reset        clock, asynchronous active-high reset
//   S, Load_AC               ALU select; commit ALU result to AC this edge
//   Load_OR                  push current (pre-edge) AC into the output FIFO
//   Wr                       memory write strobe, qualifies Mem_Wdata
//   Operand                  memory read data, ALU B operand
//   AC, Mem_Wdata            accumulator; AC gated by Wr for memory writes
//   Z, N, C, V               zero, negative, carry/borrow/shift-out, overflow
//   Illegal                  sticky: Load_AC with an unsupported S
//   Out_Data/Valid/Ready     output FIFO head with valid/ready handshake
//   Obuf_Full, Overrun       FIFO full; sticky dropped-push indicator
module acc_datapath
    import cpu_pkg::*;
#(
    parameter int WIDTH      = cpu_pkg::WIDTH,
    parameter int OBUF_DEPTH = 2
) (
    input  logic             Clock_Puls,
    input  logic             Reset,
    input  logic [3:0]       S,
    input  logic             Load_AC,
    input  logic             Load_OR,
    input  logic             Wr,
    input  logic [WIDTH-1:0] Operand,
    output logic [WIDTH-1:0] AC,
    output logic [WIDTH-1:0] Mem_Wdata,
    output logic             Z,
    output logic             N,
    output logic             C,
    output logic             V,
    output logic             Illegal,
    output logic [WIDTH-1:0] Out_Data,
    output logic             Out_Valid,
    input  logic             Out_Ready,
    output logic             Obuf_Full,
    output logic             Overrun
);

    logic [WIDTH-1:0] ac_q, ac_d;
    logic             z_q, z_d, n_q, n_d, c_q, c_d, v_q, v_d;
    logic             illegal_q, illegal_d;
    logic             overrun_q, overrun_d;

    logic [WIDTH-1:0] alu_r;
    logic             alu_c;
    logic             alu_v;
    logic [WIDTH:0]   ext;
    logic             fifo_drop;

    // ALU: A = AC, B = Operand.
    always_comb begin
        alu_r = ac_q;
        alu_c = 1'b0;
        alu_v = 1'b0;
        ext   = '0;
        case (S)
            ALU_ADD: begin
                ext   = {1'b0, ac_q} + {1'b0, Operand};
                alu_r = ext[WIDTH-1:0];
                alu_c = ext[WIDTH];
                alu_v = (ac_q[WIDTH-1] == Operand[WIDTH-1]) &&
                        (alu_r[WIDTH-1] != ac_q[WIDTH-1]);
            end
            ALU_SUB: begin
                // The extra top bit of the widened difference is the borrow.
                ext   = {1'b0, ac_q} - {1'b0, Operand};
                alu_r = ext[WIDTH-1:0];
                alu_c = ext[WIDTH];
                alu_v = (ac_q[WIDTH-1] != Operand[WIDTH-1]) &&
                        (alu_r[WIDTH-1] != ac_q[WIDTH-1]);
            end
            ALU_AND: alu_r = ac_q & Operand;
            ALU_OR:  alu_r = ac_q | Operand;
            ALU_XOR: alu_r = ac_q ^ Operand;
            ALU_SHR: begin
                alu_r = {1'b0, ac_q[WIDTH-1:1]};
                alu_c = ac_q[0];
            end
            ALU_SHL: begin
                alu_r = {ac_q[WIDTH-2:0], 1'b0};
                alu_c = ac_q[WIDTH-1];
            end
            ALU_NOT: alu_r = ~ac_q;
            default: alu_r = ac_q;
        endcase
    end

    // AC and flags change only on a legal commit; an illegal commit only
    // raises the sticky Illegal flag.
    always_comb begin
        ac_d      = ac_q;
        z_d       = z_q;
        n_d       = n_q;
        c_d       = c_q;
        v_d       = v_q;
        illegal_d = illegal_q;
        overrun_d = overrun_q | fifo_drop;
        if (Load_AC) begin
            if (alu_legal(S)) begin
                ac_d = alu_r;
                z_d  = (alu_r == '0);
                n_d  = alu_r[WIDTH-1];
                c_d  = alu_c;
                v_d  = alu_v;
            end else begin
                illegal_d = 1'b1;
            end
        end
    end

    always_ff @(posedge Clock_Puls or posedge Reset) begin
        if (Reset) begin
            ac_q      <= '0;
            z_q       <= 1'b0;
            n_q       <= 1'b0;
            c_q       <= 1'b0;
            v_q       <= 1'b0;
            illegal_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            ac_q      <= ac_d;
            z_q       <= z_d;
            n_q       <= n_d;
            c_q       <= c_d;
            v_q       <= v_d;
            illegal_q <= illegal_d;
            overrun_q <= overrun_d;
        end
    end

    // The FIFO captures ac_q, i.e. the value before this edge's commit.
    out_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (OBUF_DEPTH)
    ) u_out_fifo (
        .clk       (Clock_Puls),
        .rst       (Reset),
        .push      (Load_OR),
        .push_data (ac_q),
        .out_ready (Out_Ready),
        .out_data  (Out_Data),
        .out_valid (Out_Valid),
        .full      (Obuf_Full),
        .drop      (fifo_drop)
    );

    assign AC        = ac_q;
    assign Mem_Wdata = Wr ? ac_q : '0;
    assign Z         = z_q;
    assign N         = n_q;
    assign C         = c_q;
    assign V         = v_q;
    assign Illegal   = illegal_q;
    assign Overrun   = overrun_q;

endmodule
